// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory handshake, bounded wait timeout and sticky fault.
// Optional performance counters (instr_count, stall_count) enabled by MIPS_CTRL_PERF_EN.
module mips_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Funct,
  input  logic             mem_ready,
  output logic             MemReq,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             RegDST,
  output logic             MemtoReg,
  output logic             Branch,
  output logic             BranchNe,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUSrcA,
  output logic [2:0]       ALUSrcB,
  output logic [3:0]       ALUControl,
`ifdef MIPS_CTRL_PERF_EN
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count,
`endif
  output logic             fault
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JUMP, S_FAULT
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  state_t          state_q, state_d;
  logic [TO_W-1:0] wait_q;
  logic            rdst_q;
  logic            timeout_hit;
  logic            mem_wait;

  // wait_q counts earlier wait cycles, so this cycle is wait number MEM_TIMEOUT
  assign timeout_hit = (wait_q == TO_W'(MEM_TIMEOUT - 1));
  assign mem_wait    = MemReq & ~mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      rdst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if (mem_wait)
        wait_q <= wait_q + TO_W'(1);
      if (state_q == S_EXEC_R)
        rdst_q <= 1'b1;
      else if (state_q == S_EXEC_I)
        rdst_q <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    MemReq     = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDST     = 1'b0;
    MemtoReg   = 1'b0;
    Branch     = 1'b0;
    BranchNe   = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 3'b000;
    ALUControl = 4'b0000;
    fault      = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemReq     = 1'b1;
        ALUSrcB    = 3'b001;
        ALUControl = ALU_ADD;
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_DECODE: begin
        ALUSrcB    = 3'b010;
        ALUControl = ALU_ADD;
        case (OpCode)
          OP_R:                                       state_d = S_EXEC_R;
          OP_LW, OP_SW:                               state_d = S_MEMADR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:                             state_d = S_BRANCH;
          OP_J:                                       state_d = S_JUMP;
          default:                                    state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 3'b010;
        ALUControl = ALU_ADD;
        state_d    = (OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        if (mem_ready)        state_d = S_MEMWB;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemReq   = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready)        state_d = S_FETCH;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_EXEC_R: begin
        state_d = S_ALUWB;
        case (Funct)
          6'b100000: begin ALUSrcA = 2'b01; ALUControl = ALU_ADD; end
          6'b100010: begin ALUSrcA = 2'b01; ALUControl = ALU_SUB; end
          6'b100100: begin ALUSrcA = 2'b01; ALUControl = ALU_AND; end
          6'b100101: begin ALUSrcA = 2'b01; ALUControl = ALU_OR;  end
          6'b100110: begin ALUSrcA = 2'b01; ALUControl = ALU_XOR; end
          6'b101010: begin ALUSrcA = 2'b01; ALUControl = ALU_SLT; end
          6'b000000: begin ALUSrcA = 2'b10; ALUSrcB = 3'b011; ALUControl = ALU_SLL; end
          6'b000010: begin ALUSrcA = 2'b10; ALUSrcB = 3'b011; ALUControl = ALU_SRL; end
          6'b000011: begin ALUSrcA = 2'b10; ALUSrcB = 3'b011; ALUControl = ALU_SRA; end
          default:   state_d = S_FAULT;
        endcase
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b01;
        state_d = S_ALUWB;
        case (OpCode)
          OP_ADDI: begin ALUSrcB = 3'b010; ALUControl = ALU_ADD; end
          OP_SLTI: begin ALUSrcB = 3'b010; ALUControl = ALU_SLT; end
          OP_ANDI: begin ALUSrcB = 3'b100; ALUControl = ALU_AND; end
          OP_ORI:  begin ALUSrcB = 3'b100; ALUControl = ALU_OR;  end
          OP_XORI: begin ALUSrcB = 3'b100; ALUControl = ALU_XOR; end
          default: state_d = S_FAULT;
        endcase
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDST   = rdst_q;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b01;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        Branch     = 1'b1;
        BranchNe   = (OpCode == OP_BNE);
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_FAULT;
    endcase
  end

`ifdef MIPS_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_IDLE)
        instr_count <= instr_count + CNT_W'(1);
      if (mem_wait)
        stall_count <= stall_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed, table-driven bench for mips_multicycle_ctrl: one record per clock cycle,
// plus hand sequences for memory waits, timeouts, illegal encodings and async reset.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] OpCode = '0;
  logic [5:0] Funct = '0;
  logic       mem_ready = 1'b0;
  logic       MemReq, IorD, MemWrite, IRWrite, PCWrite, RegWrite, RegDST, MemtoReg;
  logic       Branch, BranchNe, fault;
  logic [1:0] PCSrc, ALUSrcA;
  logic [2:0] ALUSrcB;
  logic [3:0] ALUControl;
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] instr_count, stall_count;
`endif

  mips_multicycle_ctrl #(.MEM_TIMEOUT(15), .TO_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
    .MemReq(MemReq), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .RegDST(RegDST), .MemtoReg(MemtoReg),
    .Branch(Branch), .BranchNe(BranchNe), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
`ifdef MIPS_CTRL_PERF_EN
    .instr_count(instr_count), .stall_count(stall_count),
`endif
    .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        rdy;
    logic [21:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Output bundle, enables in order:
  // MemReq IorD MemWrite IRWrite PCWrite RegWrite RegDST MemtoReg Branch BranchNe
  wire [21:0] outv = {MemReq, IorD, MemWrite, IRWrite, PCWrite, RegWrite, RegDST,
                      MemtoReg, Branch, BranchNe, PCSrc, ALUSrcA, ALUSrcB, ALUControl, fault};

  function automatic logic [21:0] mk(input logic [9:0] en, input logic [1:0] pcs,
                                     input logic [1:0] asa, input logic [2:0] asb,
                                     input logic [3:0] alu, input logic flt);
    return {en, pcs, asa, asb, alu, flt};
  endfunction

  function automatic void add(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                              input logic [21:0] exp, input string nm);
    vec_t v;
    v.op = op; v.fn = fn; v.rdy = rdy; v.exp = exp; v.nm = nm;
    tbl.push_back(v);
  endfunction

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endfunction

  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                      input logic [21:0] exp, input string nm);
    OpCode = op; Funct = fn; mem_ready = rdy;
    @(negedge clk);
    check(nm, 32'(outv), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic tick(input logic [5:0] op, input logic [5:0] fn, input logic rdy);
    OpCode = op; Funct = fn; mem_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_outputs", 32'(outv), 32'd0);
`ifdef MIPS_CTRL_PERF_EN
    check("reset_instr_count", instr_count, 32'd0);
    check("reset_stall_count", stall_count, 32'd0);
`endif
    rst = 1'b1;
  endtask

  logic [21:0] ZERO, FLT, F_OK, F_WT, DEC, MADR, MRD, MWR, MWB, WB_R, WB_I;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, ORI = 6'b001101;
  localparam logic [5:0] SLTI = 6'b001010, BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ZERO = '0;
    FLT  = mk(10'b0000000000, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b1);
    F_OK = mk(10'b1001100000, 2'b00, 2'b00, 3'b001, 4'b0010, 1'b0);
    F_WT = mk(10'b1000000000, 2'b00, 2'b00, 3'b001, 4'b0010, 1'b0);
    DEC  = mk(10'b0000000000, 2'b00, 2'b00, 3'b010, 4'b0010, 1'b0);
    MADR = mk(10'b0000000000, 2'b00, 2'b01, 3'b010, 4'b0010, 1'b0);
    MRD  = mk(10'b1100000000, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0);
    MWR  = mk(10'b1110000000, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0);
    MWB  = mk(10'b0000010100, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0);
    WB_R = mk(10'b0000011000, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0);
    WB_I = mk(10'b0000010000, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0);

    add(R, 6'h00, 1'b1, ZERO, "idle");
    add(R, 6'h20, 1'b1, F_OK, "add_fetch");
    add(R, 6'h20, 1'b1, DEC,  "add_decode");
    add(R, 6'h20, 1'b1, mk(10'b0, 2'b00, 2'b01, 3'b000, 4'b0010, 1'b0), "add_exec");
    add(R, 6'h20, 1'b1, WB_R, "add_wb");
    add(ORI, 6'h00, 1'b1, F_OK, "ori_fetch");
    add(ORI, 6'h00, 1'b1, DEC,  "ori_decode");
    add(ORI, 6'h00, 1'b1, mk(10'b0, 2'b00, 2'b01, 3'b100, 4'b0001, 1'b0), "ori_exec");
    add(ORI, 6'h00, 1'b1, WB_I, "ori_wb");
    add(R, 6'h03, 1'b1, F_OK, "sra_fetch");
    add(R, 6'h03, 1'b1, DEC,  "sra_decode");
    add(R, 6'h03, 1'b1, mk(10'b0, 2'b00, 2'b10, 3'b011, 4'b1010, 1'b0), "sra_exec");
    add(R, 6'h03, 1'b1, WB_R, "sra_wb");
    add(SLTI, 6'h00, 1'b1, F_OK, "slti_fetch");
    add(SLTI, 6'h00, 1'b1, DEC,  "slti_decode");
    add(SLTI, 6'h00, 1'b1, mk(10'b0, 2'b00, 2'b01, 3'b010, 4'b0111, 1'b0), "slti_exec");
    add(SLTI, 6'h00, 1'b1, WB_I, "slti_wb");
    add(SW, 6'h00, 1'b1, F_OK, "sw_fetch");
    add(SW, 6'h00, 1'b1, DEC,  "sw_decode");
    add(SW, 6'h00, 1'b1, MADR, "sw_memadr");
    add(SW, 6'h00, 1'b1, MWR,  "sw_memwr");
    add(LW, 6'h00, 1'b1, F_OK, "lw_fetch");
    add(LW, 6'h00, 1'b1, DEC,  "lw_decode");
    add(LW, 6'h00, 1'b1, MADR, "lw_memadr");
    add(LW, 6'h00, 1'b1, MRD,  "lw_memrd");
    add(LW, 6'h00, 1'b1, MWB,  "lw_memwb");
    add(BNE, 6'h00, 1'b1, F_OK, "bne_fetch");
    add(BNE, 6'h00, 1'b1, DEC,  "bne_decode");
    add(BNE, 6'h00, 1'b1, mk(10'b0000000011, 2'b01, 2'b01, 3'b000, 4'b0110, 1'b0), "bne_branch");
    add(BEQ, 6'h00, 1'b1, F_OK, "beq_fetch");
    add(BEQ, 6'h00, 1'b1, DEC,  "beq_decode");
    add(BEQ, 6'h00, 1'b1, mk(10'b0000000010, 2'b01, 2'b01, 3'b000, 4'b0110, 1'b0), "beq_branch");
    add(J, 6'h00, 1'b1, F_OK, "j_fetch");
    add(J, 6'h00, 1'b1, DEC,  "j_decode");
    add(J, 6'h00, 1'b1, mk(10'b0000100000, 2'b10, 2'b00, 3'b000, 4'b0000, 1'b0), "j_jump");

    do_reset();
    foreach (tbl[i]) step(tbl[i].op, tbl[i].fn, tbl[i].rdy, tbl[i].exp, tbl[i].nm);
`ifdef MIPS_CTRL_PERF_EN
    check("instr_count_table", instr_count, 32'd9);
    check("stall_count_table", stall_count, 32'd0);
`endif

    // lw with three wait cycles in MEMRD: 8 cycles, then back to FETCH
    step(LW, 6'h00, 1'b1, F_OK, "lwd_fetch");
    step(LW, 6'h00, 1'b1, DEC,  "lwd_decode");
    step(LW, 6'h00, 1'b1, MADR, "lwd_memadr");
    for (int i = 0; i < 3; i++) step(LW, 6'h00, 1'b0, MRD, "lwd_memrd_wait");
    step(LW, 6'h00, 1'b1, MRD, "lwd_memrd_done");
    step(LW, 6'h00, 1'b1, MWB, "lwd_memwb");
`ifdef MIPS_CTRL_PERF_EN
    check("lwd_stall_count", stall_count, 32'd3);
    check("lwd_instr_count", instr_count, 32'd10);
`endif

    // mem_ready on the 15th wait cycle still completes the fetch
    for (int i = 0; i < 14; i++) step(R, 6'h20, 1'b0, F_WT, "late_fetch_wait");
    step(R, 6'h20, 1'b1, F_OK, "late_fetch_ok");
    step(R, 6'h20, 1'b1, DEC,  "late_decode");
    step(R, 6'h20, 1'b1, mk(10'b0, 2'b00, 2'b01, 3'b000, 4'b0010, 1'b0), "late_exec");
    step(R, 6'h20, 1'b1, WB_R, "late_wb");

    // 15 unanswered wait cycles -> FAULT, which then holds regardless of mem_ready
    for (int i = 0; i < 15; i++) step(R, 6'h20, 1'b0, F_WT, "to_fetch_wait");
    for (int i = 0; i < 20; i++) step(R, 6'h20, 1'(i % 2), FLT, "fault_hold");
`ifdef MIPS_CTRL_PERF_EN
    check("to_stall_count", stall_count, 32'd32);
    check("to_instr_count", instr_count, 32'd11);
`endif
    #3 rst = 1'b0;
    #1 check("async_rst_clears_fault", 32'(outv), 32'd0);
`ifdef MIPS_CTRL_PERF_EN
    check("async_rst_counters", instr_count | stall_count, 32'd0);
`endif
    @(posedge clk); #1 rst = 1'b1;

    // illegal opcode
    step(6'h3F, 6'h00, 1'b1, ZERO, "ill_op_idle");
    step(6'h3F, 6'h00, 1'b1, F_OK, "ill_op_fetch");
    step(6'h3F, 6'h00, 1'b1, DEC,  "ill_op_decode");
    step(6'h3F, 6'h00, 1'b1, FLT,  "ill_op_fault");
    do_reset();

    // illegal R-type funct (jr encoding)
    step(R, 6'b001000, 1'b1, ZERO, "ill_fn_idle");
    step(R, 6'b001000, 1'b1, F_OK, "ill_fn_fetch");
    step(R, 6'b001000, 1'b1, DEC,  "ill_fn_decode");
    tick(R, 6'b001000, 1'b1);
    step(R, 6'b001000, 1'b1, FLT,  "ill_fn_fault");
    do_reset();

    // MEMRD timeout
    step(LW, 6'h00, 1'b1, ZERO, "rdto_idle");
    step(LW, 6'h00, 1'b1, F_OK, "rdto_fetch");
    step(LW, 6'h00, 1'b1, DEC,  "rdto_decode");
    step(LW, 6'h00, 1'b1, MADR, "rdto_memadr");
    for (int i = 0; i < 15; i++) step(LW, 6'h00, 1'b0, MRD, "rdto_wait");
    step(LW, 6'h00, 1'b1, FLT, "rdto_fault");
    do_reset();

    // reset mid-access drops MemReq immediately
    step(SW, 6'h00, 1'b1, ZERO, "midrst_idle");
    step(SW, 6'h00, 1'b0, F_WT, "midrst_fetch_wait");
    #3 rst = 1'b0;
    #1 check("midrst_memreq_drop", 32'(outv), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
